bit_index_serializer: RTL and testbench
=======================================

BIT_INDEX_SERIALIZER -- requirements
Module: bit_index_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: input word width, power of two, at least 2.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port arst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data_i, input, WIDTH bits: word whose set-bit positions are to be emitted.
REQ-005 The block SHALL have port data_val_i, input, 1 bit: data_i valid.
REQ-006 The block SHALL have port data_ready_o, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port idx_o, output, $clog2(WIDTH) bits: index of one set bit.
REQ-008 The block SHALL have port idx_val_o, output, 1 bit: the idx_o/idx_last_o/idx_empty_o/count_o beat is valid.
REQ-009 The block SHALL have port idx_ready_i, input, 1 bit: downstream accepts the beat.
REQ-010 The block SHALL have port idx_last_o, output, 1 bit: final beat for the current word.
REQ-011 The block SHALL have port idx_empty_o, output, 1 bit: the captured word was all-zero; idx_o is meaningless on this beat.
REQ-012 The block SHALL have port count_o, output, $clog2(WIDTH)+1 bits: population count of the captured word.

Function
REQ-013 Input handshake: a word SHALL be captured on a rising edge with data_val_i=1 and data_ready_o=1; data_val_i while data_ready_o=0 is ignored, with no buffering.
REQ-014 FSM states: IDLE and EMIT; data_ready_o SHALL be 1 only in IDLE.
REQ-015 IDLE->EMIT on capture: register the word as the remaining mask, register count_o = popcount(word), and register the empty flag = (word==0).
REQ-016 In EMIT, idx_val_o SHALL be 1, and idx_o SHALL be the index of the lowest set bit of the remaining mask (ascending order, LSB first).
REQ-017 idx_last_o SHALL be 1 when the remaining mask has exactly one set bit, or when the empty flag is set.
REQ-018 Output handshake: a beat SHALL complete on a rising edge with idx_val_o=1 and idx_ready_i=1; that edge clears the emitted bit from the remaining mask.
REQ-019 Backpressure: while idx_val_o=1 and idx_ready_i=0, idx_o, idx_last_o, idx_empty_o and count_o SHALL hold stable.
REQ-020 EMIT->IDLE SHALL occur on the handshake of the beat with idx_last_o=1; otherwise the FSM stays in EMIT.
REQ-021 All-zero word: exactly one beat SHALL be emitted with idx_empty_o=1, idx_last_o=1, count_o=0, idx_o=0.
REQ-022 count_o SHALL be constant across all beats of one word; width $clog2(WIDTH)+1 holds the value WIDTH without overflow.
REQ-023 Latency: the first beat SHALL be valid in the cycle after capture, and a word with N set bits SHALL take max(N,1) beats.
REQ-024 Throughput: with idx_ready_i held at 1, the block SHALL emit one beat per cycle, with one IDLE cycle between words (data_ready_o rises the cycle after the last handshake).
REQ-025 Changes on data_i in EMIT SHALL have no effect on output.

Reset
REQ-026 While arst_n_i=0, outputs SHALL be forced asynchronously to: data_ready_o=0, idx_val_o=0, idx_o=0, idx_last_o=0, idx_empty_o=0, count_o=0; state=IDLE, mask=0.
REQ-027 After arst_n_i deasserts, data_ready_o SHALL be 1 from the first clock edge onward.
REQ-028 Reset during EMIT SHALL discard the in-flight word, with no further beats for it after reset release.

Verification (WIDTH=8)
REQ-029 data_i=0xA5 accepted, idx_ready_i=1 -> beats idx 0,2,5,7 on consecutive cycles, count_o=4, idx_last_o only on idx 7, data_ready_o=1 the next cycle.
REQ-030 data_i=0x00 -> single beat: idx_empty_o=1, idx_last_o=1, count_o=0, then return to IDLE.
REQ-031 data_i=0xFF, idx_ready_i toggling 1,0,1,0... -> indices 0..7 in order, each held stable through ready-low cycles, count_o=8 throughout, last on idx 7.
REQ-032 data_i=0x80 -> one beat idx 7, idx_last_o=1, count_o=1; then 0x03 offered back-to-back with data_val_i held high -> captured only after the IDLE cycle, beats idx 0,1.
REQ-033 data_i=0x5A accepted; arst_n_i pulsed low after the first beat -> idx_val_o=0 immediately, no beats for 0x5A after release, data_ready_o=1 on the first edge after release.

Source files
------------

// File: rtl/bit_index_serializer.sv
// Accepts one word at a time and streams out the index of every set bit, LSB first,
// one beat per handshake, tagged with the word's popcount and an all-zero flag.
module bit_index_serializer #(
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       data_val_i,
    output logic                       data_ready_o,
    output logic [$clog2(WIDTH)-1:0]   idx_o,
    output logic                       idx_val_o,
    input  logic                       idx_ready_i,
    output logic                       idx_last_o,
    output logic                       idx_empty_o,
    output logic [$clog2(WIDTH):0]     count_o
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  mask_clr;
    logic              data_ready_q;
    logic              idx_val_q;
    logic [IW-1:0]     idx_q;
    logic              last_q;
    logic              empty_q;
    logic [CW-1:0]     count_q;

    function automatic logic [IW-1:0] lowest_idx(input logic [WIDTH-1:0] m);
        lowest_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IW'(i);
        end
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] m);
        popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcount = popcount + CW'(m[i]);
        end
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] m);
        single_bit = (m != '0) && ((m & (m - WIDTH'(1))) == '0);
    endfunction

    // Remaining mask with its lowest set bit removed
    assign mask_clr = mask_q & (mask_q - WIDTH'(1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            data_ready_q <= 1'b0;
            idx_val_q    <= 1'b0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            empty_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_ready_q <= 1'b1;
                    if (data_val_i && data_ready_q) begin
                        state_q      <= EMIT;
                        data_ready_q <= 1'b0;
                        idx_val_q    <= 1'b1;
                        mask_q       <= data_i;
                        count_q      <= popcount(data_i);
                        empty_q      <= (data_i == '0);
                        idx_q        <= lowest_idx(data_i);
                        last_q       <= (data_i == '0) || single_bit(data_i);
                    end
                end
                EMIT: begin
                    if (idx_ready_i) begin
                        if (last_q) begin
                            state_q      <= IDLE;
                            data_ready_q <= 1'b1;
                            idx_val_q    <= 1'b0;
                            mask_q       <= '0;
                            last_q       <= 1'b0;
                            empty_q      <= 1'b0;
                        end else begin
                            mask_q <= mask_clr;
                            idx_q  <= lowest_idx(mask_clr);
                            last_q <= single_bit(mask_clr);
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    data_ready_q <= 1'b0;
                    idx_val_q    <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o = data_ready_q;
    assign idx_val_o    = idx_val_q;
    assign idx_o        = idx_q;
    assign idx_last_o   = last_q;
    assign idx_empty_o  = empty_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed bench for bit_index_serializer at WIDTH=8: table of words with expected
// index sequences, plus hand-written back-to-back and mid-word reset sequences.
module tb_bit_index_serializer;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] data_i;
    logic       data_val_i;
    logic       data_ready_o;
    logic [2:0] idx_o;
    logic       idx_val_o;
    logic       idx_ready_i;
    logic       idx_last_o;
    logic       idx_empty_o;
    logic [3:0] count_o;

    int total = 0;
    int bad   = 0;

    bit_index_serializer #(.WIDTH(8)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .idx_o        (idx_o),
        .idx_val_o    (idx_val_o),
        .idx_ready_i  (idx_ready_i),
        .idx_last_o   (idx_last_o),
        .idx_empty_o  (idx_empty_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  cnt;
        int          nb;
        logic [31:0] idxs;   // beat k expected index in idxs[4k +: 3]
        bit          toggle;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic run_word(input logic [7:0] d, input logic [3:0] ecnt, input int nb,
                            input logic [31:0] idxs, input bit toggle);
        int guard;
        int beat;
        int cyc;
        bit ph;
        bit r;
        guard = 0;
        while (!data_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_word", int'(data_ready_o), 1);
        data_i     = d;
        data_val_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_val_i = 1'b0;
        data_i     = ~d;
        beat = 0;
        cyc  = 0;
        ph   = 1'b0;
        while (beat < nb && cyc < 40) begin
            chk("beat_val",   int'(idx_val_o),   1);
            chk("beat_idx",   int'(idx_o),       int'(idxs[4*beat +: 3]));
            chk("beat_last",  int'(idx_last_o),  int'(beat == nb - 1));
            chk("beat_empty", int'(idx_empty_o), int'(ecnt == 0));
            chk("beat_count", int'(count_o),     int'(ecnt));
            chk("beat_noready", int'(data_ready_o), 0);
            r  = toggle ? !ph : 1'b1;
            ph = !ph;
            idx_ready_i = r;
            @(negedge clk);
            cyc++;
            if (r) beat++;
        end
        chk("beats_done_in_budget", int'(beat), nb);
        chk("after_word_val",   int'(idx_val_o),    0);
        chk("after_word_ready", int'(data_ready_o), 1);
        idx_ready_i = 1'b1;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, cnt: 4'd4, nb: 4, idxs: 32'h0000_7520, toggle: 1'b0};
        vecs[1] = '{data: 8'h00, cnt: 4'd0, nb: 1, idxs: 32'h0000_0000, toggle: 1'b0};
        vecs[2] = '{data: 8'hFF, cnt: 4'd8, nb: 8, idxs: 32'h7654_3210, toggle: 1'b1};
        vecs[3] = '{data: 8'h5A, cnt: 4'd4, nb: 4, idxs: 32'h0000_6431, toggle: 1'b1};
        vecs[4] = '{data: 8'h10, cnt: 4'd1, nb: 1, idxs: 32'h0000_0004, toggle: 1'b0};
        vecs[5] = '{data: 8'h01, cnt: 4'd1, nb: 1, idxs: 32'h0000_0000, toggle: 1'b1};

        arst_n      = 1'b0;
        data_i      = 8'h00;
        data_val_i  = 1'b0;
        idx_ready_i = 1'b1;
        #2;
        chk("rst_ready", int'(data_ready_o), 0);
        chk("rst_val",   int'(idx_val_o),    0);
        chk("rst_idx",   int'(idx_o),        0);
        chk("rst_last",  int'(idx_last_o),   0);
        chk("rst_empty", int'(idx_empty_o),  0);
        chk("rst_count", int'(count_o),      0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", int'(data_ready_o), 1);

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].data, vecs[i].cnt, vecs[i].nb, vecs[i].idxs, vecs[i].toggle);
        end

        // 0x80 then 0x03 offered with data_val held high across the beat
        data_i      = 8'h80;
        data_val_i  = 1'b1;
        idx_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_80_idx",   int'(idx_o),      7);
        chk("b2b_80_last",  int'(idx_last_o), 1);
        chk("b2b_80_count", int'(count_o),    1);
        data_i = 8'h03;
        @(negedge clk);
        chk("b2b_gap_val",   int'(idx_val_o),    0);
        chk("b2b_gap_ready", int'(data_ready_o), 1);
        @(negedge clk);
        data_val_i = 1'b0;
        chk("b2b_03_val0",  int'(idx_val_o),  1);
        chk("b2b_03_idx0",  int'(idx_o),      0);
        chk("b2b_03_last0", int'(idx_last_o), 0);
        chk("b2b_03_count", int'(count_o),    2);
        @(negedge clk);
        chk("b2b_03_idx1",  int'(idx_o),      1);
        chk("b2b_03_last1", int'(idx_last_o), 1);
        @(negedge clk);
        chk("b2b_03_done",  int'(idx_val_o),  0);

        // Reset in the middle of 0x5A
        data_i     = 8'h5A;
        data_val_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_val_i = 1'b0;
        chk("rst5a_first_idx", int'(idx_o), 1);
        @(negedge clk);
        chk("rst5a_second_idx", int'(idx_o), 3);
        #1 arst_n = 1'b0;
        #1;
        chk("rst5a_val_async",   int'(idx_val_o),    0);
        chk("rst5a_ready_async", int'(data_ready_o), 0);
        chk("rst5a_count_async", int'(count_o),      0);
        chk("rst5a_idx_async",   int'(idx_o),        0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("rst5a_ready_release", int'(data_ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            chk("rst5a_no_beats", int'(idx_val_o), 0);
            @(negedge clk);
        end

        run_word(8'h0C, 4'd2, 2, 32'h0000_0032, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
